// File: rtl/sync_evt_hs_arb_pkg.sv
// Shared types and helpers for the event handshake arbiter: FSM encoding,
// ID width derivation and the round-robin index wrap.
package sync_evt_hs_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_REL  = 2'b10
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ID_W    = id_width(DEF_NUM_REQ);

  // Index reached by stepping 'off' places up from 'ptr' in a ring of n.
  function automatic int rr_index(input int ptr, input int off, input int n);
    return (ptr + off >= n) ? (ptr + off - n) : (ptr + off);
  endfunction

endpackage

// File: rtl/sync_evt_hs_arb_if.sv
// Requester events plus the req/ack/id channel toward the destination domain.
interface sync_evt_hs_arb_if
  import sync_evt_hs_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
);
  logic [NUM_REQ-1:0] evt_pulse;
  logic [NUM_REQ-1:0] evt_pend;
  logic [NUM_REQ-1:0] evt_ovf;
  logic [NUM_REQ-1:0] evt_done;
  logic               req_out;
  logic [ID_W-1:0]    req_id;
  logic               ack_in;
  logic               busy;

  modport slave (
    input  evt_pulse, ack_in,
    output evt_pend, evt_ovf, evt_done, req_out, req_id, busy
  );

  modport master (
    output evt_pulse, ack_in,
    input  evt_pend, evt_ovf, evt_done, req_out, req_id, busy
  );
endinterface

// File: rtl/sync_evt_rr_pick.sv
// Round-robin picker: first pending bit strictly above ptr, wrapping around.
module sync_evt_rr_pick
  import sync_evt_hs_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gid,
  output logic               any
);
  // Walk from the farthest offset down so the nearest pending bit wins last.
  always_comb begin
    grant = '0;
    gid   = '0;
    any   = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (pend[rr_index(int'(ptr), off, NUM_REQ)]) begin
        grant = '0;
        grant[rr_index(int'(ptr), off, NUM_REQ)] = 1'b1;
        gid   = ID_W'(rr_index(int'(ptr), off, NUM_REQ));
        any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sync_level2level.sv
// Two-flop level synchronizer for a slowly changing asynchronous level.
module sync_level2level (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];
endmodule

// File: rtl/sync_evt_hs_arb.sv
// Shares one 4-phase req/ack crossing between NUM_REQ event sources,
// pending their pulses and granting them round-robin.
module sync_evt_hs_arb
  import sync_evt_hs_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_b,
  sync_evt_hs_arb_if.slave  bus
);
  logic               ack_s;
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic [NUM_REQ-1:0] clr;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] ovf_q, ovf_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               req_out_q, req_out_d;
  logic [ID_W-1:0]    req_id_q, req_id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  sync_level2level u_ack_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .d     (bus.ack_in),
    .q     (ack_s)
  );

  sync_evt_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .pend  (pend_q),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .gid   (pick_id),
    .any   (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    req_out_d = req_out_q;
    req_id_d  = req_id_q;
    ptr_d     = ptr_q;
    done_d    = '0;
    clr       = '0;
    case (state_q)
      // A stale ack still high from the previous transfer blocks new grants.
      ST_IDLE: if (pick_any && !ack_s) begin
        clr       = pick_grant;
        req_id_d  = pick_id;
        req_out_d = 1'b1;
        ptr_d     = pick_id;
        state_d   = ST_REQ;
      end
      ST_REQ: if (ack_s) begin
        req_out_d = 1'b0;
        done_d    = NUM_REQ'(1) << req_id_q;
        state_d   = ST_REL;
      end
      ST_REL: if (!ack_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A new pulse on the bit being granted re-pends it.
    pend_d = (pend_q & ~clr) | bus.evt_pulse;
    ovf_d  = bus.evt_pulse & pend_q & ~clr;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      ovf_q     <= '0;
      done_q    <= '0;
      req_out_q <= 1'b0;
      req_id_q  <= '0;
      ptr_q     <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      req_out_q <= req_out_d;
      req_id_q  <= req_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.evt_pend = pend_q;
  assign bus.evt_ovf  = ovf_q;
  assign bus.evt_done = done_q;
  assign bus.req_out  = req_out_q;
  assign bus.req_id   = req_id_q;
  assign bus.busy     = (state_q != ST_IDLE);
endmodule
